// File: rtl/register_file.sv
// register_file: DEPTH x WIDTH register file with one write port, two registered
// read ports carrying per-entry valid flags, and a one-entry-per-cycle clear sweep.
module register_file #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] in,
  input  logic             rd_en_a,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] out_a,
  output logic             valid_a,
  input  logic             rd_en_b,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] out_b,
  output logic             valid_b,
  input  logic             clr,
  output logic             busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  state_t           state_r, state_nx_s;
  logic [AW-1:0]    cnt_r, cnt_nx_s;
  logic             busy_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             vld_r [DEPTH];
  logic [WIDTH-1:0] out_a_r, out_b_r, rd_a_data_s, rd_b_data_s;
  logic             valid_a_r, valid_b_r, rd_a_vld_s, rd_b_vld_s;
  logic             wr_acc_s, clear_s, a_rng_s, b_rng_s;

  // Write is accepted only when idle, not beaten by clr, and in range.
  assign wr_acc_s = wr_en && (state_r == IDLE) && !clr && ({1'b0, wr_addr} < DEPTH_C);
  assign clear_s  = (state_r == CLEAR);
  assign a_rng_s  = ({1'b0, rd_addr_a} < DEPTH_C);
  assign b_rng_s  = ({1'b0, rd_addr_b} < DEPTH_C);

  // Sweep FSM next-state and counter sequencing.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      IDLE: begin
        cnt_nx_s = '0;
        if (clr) begin
          state_nx_s = CLEAR;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CLEAR: begin
        if (cnt_r == LAST_C) begin
          state_nx_s = IDLE;
          cnt_nx_s   = '0;
        end else begin
          state_nx_s = CLEAR;
          cnt_nx_s   = cnt_r + AW'(1'b1);
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = '0;
      end
    endcase
  end

  // FSM state, sweep counter and busy flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      busy_r  <= (state_nx_s == CLEAR);
    end
  end

  // Storage: sweep clears one entry per cycle, otherwise accepted writes land.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_r[i] <= RESET_VAL;
        vld_r[i] <= 1'b0;
      end
    end else if (clear_s) begin
      mem_r[cnt_r] <= RESET_VAL;
      vld_r[cnt_r] <= 1'b0;
    end else if (wr_acc_s) begin
      mem_r[wr_addr] <= in;
      vld_r[wr_addr] <= 1'b1;
    end
  end

  // Read data selection: out-of-range reads zero, same-address write bypasses.
  always_comb begin
    rd_a_data_s = '0;
    rd_a_vld_s  = 1'b0;
    if (!a_rng_s) begin
      rd_a_data_s = '0;
      rd_a_vld_s  = 1'b0;
    end else if (wr_acc_s && (wr_addr == rd_addr_a)) begin
      rd_a_data_s = in;
      rd_a_vld_s  = 1'b1;
    end else begin
      rd_a_data_s = mem_r[rd_addr_a];
      rd_a_vld_s  = vld_r[rd_addr_a];
    end
  end

  // Port B mirror of the port A selection.
  always_comb begin
    rd_b_data_s = '0;
    rd_b_vld_s  = 1'b0;
    if (!b_rng_s) begin
      rd_b_data_s = '0;
      rd_b_vld_s  = 1'b0;
    end else if (wr_acc_s && (wr_addr == rd_addr_b)) begin
      rd_b_data_s = in;
      rd_b_vld_s  = 1'b1;
    end else begin
      rd_b_data_s = mem_r[rd_addr_b];
      rd_b_vld_s  = vld_r[rd_addr_b];
    end
  end

  // Registered read ports; they hold while their strobe is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_a_r   <= '0;
      valid_a_r <= 1'b0;
      out_b_r   <= '0;
      valid_b_r <= 1'b0;
    end else begin
      if (rd_en_a) begin
        out_a_r   <= rd_a_data_s;
        valid_a_r <= rd_a_vld_s;
      end
      if (rd_en_b) begin
        out_b_r   <= rd_b_data_s;
        valid_b_r <= rd_b_vld_s;
      end
    end
  end

  assign out_a   = out_a_r;
  assign valid_a = valid_a_r;
  assign out_b   = out_b_r;
  assign valid_b = valid_b_r;
  assign busy    = busy_r;

endmodule
